// File: rtl/types.sv
// Shared NoC types: node IDs, flit layout and the reserved destination IDs.
package types;

  typedef logic [7:0] node_id_t;

  typedef struct packed {
    node_id_t    src_id;
    node_id_t    dst_id;
    logic [31:0] payload;
  } flit_t;

  localparam node_id_t BROADCAST_ID = 8'hFF;
  localparam node_id_t ROOT_ID      = 8'h00;

  // Destination match plus self-echo rejection: a node never keeps its own flits.
  function automatic logic is_addr_match(input flit_t f, input node_id_t my_id,
                                         input logic is_root);
    logic w_dst_ok;
    w_dst_ok = (f.dst_id == my_id) || (f.dst_id == BROADCAST_ID) ||
               (is_root && (f.dst_id == ROOT_ID));
    return w_dst_ok && (f.src_id != my_id);
  endfunction

endpackage

// File: rtl/flit_fifo.sv
// Power-of-two receive FIFO over types::flit_t with registered pointers and level.
module flit_fifo
  import types::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  flit_t                  push_data,
  input  logic                   pop,
  output flit_t                  head,
  output logic                   head_valid,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  flit_t              r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [LVL_W-1:0]   r_level;
  logic               w_push;
  logic               w_pop;

  assign full       = (r_level == FULL_LVL);
  assign head_valid = (r_level != {LVL_W{1'b0}});
  assign w_push     = push & ~full;
  assign w_pop      = pop & head_valid;
  assign level      = r_level;
  // Head is forced to zero when empty so reset/empty never exposes stale storage.
  assign head       = head_valid ? r_mem[r_rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_level  <= {LVL_W{1'b0}};
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/normal_flit_receiver.sv
// Link-side flit receiver: address filtering, saturating counters, buffered output.
module normal_flit_receiver
  import types::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter bit IS_ROOT    = 1'b0
) (
  input  logic                        nocclk,
  input  logic                        rst_n,
  input  node_id_t                    this_node_id,
  input  flit_t                       flit_in,
  input  logic                        flit_in_valid,
  output logic                        flit_in_ready,
  output flit_t                       flit_out,
  output logic                        flit_out_valid,
  input  logic                        flit_out_ready,
  output logic [15:0]                 accept_count,
  output logic [15:0]                 drop_count,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  logic        r_ready_en;
  logic [15:0] r_accept_count;
  logic [15:0] r_drop_count;
  logic        w_full;
  logic        w_xfer;
  logic        w_match;
  logic        w_accept;
  logic        w_drop;

  // Ready is built purely from registers; r_ready_en holds it low until the first edge out of reset.
  assign flit_in_ready = r_ready_en & ~w_full;
  assign w_xfer        = flit_in_valid & flit_in_ready;
  assign w_match       = is_addr_match(flit_in, this_node_id, IS_ROOT);
  assign w_accept      = w_xfer & w_match;
  assign w_drop        = w_xfer & ~w_match;
  assign accept_count  = r_accept_count;
  assign drop_count    = r_drop_count;

  flit_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (nocclk),
    .rst_n     (rst_n),
    .push      (w_accept),
    .push_data (flit_in),
    .pop       (flit_out_ready),
    .head      (flit_out),
    .head_valid(flit_out_valid),
    .full      (w_full),
    .level     (fifo_level)
  );

  always_ff @(posedge nocclk or negedge rst_n) begin
    if (!rst_n) begin
      r_ready_en     <= 1'b0;
      r_accept_count <= 16'h0000;
      r_drop_count   <= 16'h0000;
    end else begin
      r_ready_en <= 1'b1;
      if (w_accept && (r_accept_count != CNT_MAX)) begin
        r_accept_count <= r_accept_count + 16'h0001;
      end
      if (w_drop && (r_drop_count != CNT_MAX)) begin
        r_drop_count <= r_drop_count + 16'h0001;
      end
    end
  end

endmodule

// File: tb/tb_normal_flit_receiver.sv
// Scoreboard bench: driver keeps a queue-level model, monitor checks every pop in order.
module tb_normal_flit_receiver;
  import types::*;

  localparam int       DEPTH = 4;
  localparam node_id_t MY_ID = 8'd5;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  flit_t       fin, fout;
  logic        fvalid, fready, fovalid, fordy;
  logic [15:0] acc, drp;
  logic [2:0]  lvl;

  flit_t       r_fin, r_fout;
  logic        r_fvalid, r_fready, r_fovalid;
  logic [15:0] r_acc, r_drp;
  logic [2:0]  r_lvl;

  normal_flit_receiver #(.FIFO_DEPTH(DEPTH), .IS_ROOT(1'b0)) dut (
    .nocclk(clk), .rst_n(rst_n), .this_node_id(MY_ID),
    .flit_in(fin), .flit_in_valid(fvalid), .flit_in_ready(fready),
    .flit_out(fout), .flit_out_valid(fovalid), .flit_out_ready(fordy),
    .accept_count(acc), .drop_count(drp), .fifo_level(lvl));

  normal_flit_receiver #(.FIFO_DEPTH(DEPTH), .IS_ROOT(1'b1)) dut_root (
    .nocclk(clk), .rst_n(rst_n), .this_node_id(MY_ID),
    .flit_in(r_fin), .flit_in_valid(r_fvalid), .flit_in_ready(r_fready),
    .flit_out(r_fout), .flit_out_valid(r_fovalid), .flit_out_ready(1'b1),
    .accept_count(r_acc), .drop_count(r_drp), .fifo_level(r_lvl));

  int    n_tests = 0;
  int    n_fail  = 0;
  flit_t exp_q[$];
  int    m_level, m_acc, m_drop;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_match(input flit_t f, input bit root);
    if (f.src_id == MY_ID) return 1'b0;
    return (f.dst_id == MY_ID) || (f.dst_id == BROADCAST_ID) || (root && f.dst_id == ROOT_ID);
  endfunction

  function automatic flit_t mk(input node_id_t s, input node_id_t d, input logic [31:0] p);
    flit_t f;
    f.src_id = s; f.dst_id = d; f.payload = p;
    return f;
  endfunction

  // One cycle at posedge+1: check model state, predict this cycle's transfer, advance.
  task automatic cycle(input logic v, input flit_t f, input logic ordy, output bit consumed);
    bit rdy, push, pop;
    fin = f; fvalid = v; fordy = ordy;
    rdy = (m_level != DEPTH);
    chk("in_ready", {63'd0, fready}, {63'd0, rdy});
    chk("out_valid", {63'd0, fovalid}, {63'd0, (m_level > 0)});
    chk("fifo_level", {61'd0, lvl}, 64'(m_level));
    chk("accept_count", {48'd0, acc}, 64'(m_acc));
    chk("drop_count", {48'd0, drp}, 64'(m_drop));
    push = v && rdy && model_match(f, 1'b0);
    pop  = ordy && (m_level > 0);
    if (v && rdy) begin
      if (push) begin
        exp_q.push_back(f);
        if (m_acc < 65535) m_acc++;
      end else if (m_drop < 65535) begin
        m_drop++;
      end
    end
    m_level = m_level + int'(push) - int'(pop);
    consumed = v && rdy;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_in_ready", {63'd0, fready}, 64'd0);
    chk("rst_out_valid", {63'd0, fovalid}, 64'd0);
    chk("rst_level", {61'd0, lvl}, 64'd0);
    chk("rst_acc", {48'd0, acc}, 64'd0);
    chk("rst_drop", {48'd0, drp}, 64'd0);
    chk("rst_flit_out", 64'(fout), 64'd0);
    chk("rst_root_acc", {48'd0, r_acc}, 64'd0);
    exp_q.delete();
    m_level = 0; m_acc = 0; m_drop = 0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Monitor: every pop the DUT performs must match the oldest expected flit.
  always @(negedge clk) begin
    flit_t e;
    if (rst_n === 1'b1 && fovalid === 1'b1 && fordy === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL scoreboard: unexpected pop %0h, expected none", fout);
      end else begin
        e = exp_q.pop_front();
        chk("flit_out_order", 64'(fout), 64'(e));
      end
    end
  end

  initial begin
    bit    c;
    int    idx;
    flit_t fl [6];
    flit_t rf;
    node_id_t s, d;

    rst_n = 1'b0; fvalid = 1'b0; fordy = 1'b0; fin = '0;
    r_fvalid = 1'b0; r_fin = '0;
    @(posedge clk); #1;
    do_reset();

    // dst 5, 7, broadcast
    cycle(1'b1, mk(8'd3, 8'd5, 32'hA0), 1'b1, c);
    cycle(1'b1, mk(8'd3, 8'd7, 32'hA1), 1'b1, c);
    cycle(1'b1, mk(8'd3, BROADCAST_ID, 32'hA2), 1'b1, c);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, c);
    chk("acc_after_three", {48'd0, acc}, 64'd2);
    chk("drop_after_three", {48'd0, drp}, 64'd1);

    // self-echo
    do_reset();
    cycle(1'b1, mk(MY_ID, MY_ID, 32'hB0), 1'b1, c);
    for (int i = 0; i < 2; i++) cycle(1'b0, '0, 1'b1, c);
    chk("echo_drop", {48'd0, drp}, 64'd1);
    chk("echo_valid", {63'd0, fovalid}, 64'd0);

    // fill to full, pop once, re-offer across wrap
    do_reset();
    for (int i = 0; i < 6; i++) fl[i] = mk(8'd2, MY_ID, 32'hC0 + 32'(i));
    idx = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, fl[idx], 1'b0, c);
      if (c) idx++;
    end
    chk("full_accepted", 64'(idx), 64'd4);
    cycle(1'b1, fl[idx], 1'b1, c);
    if (c) idx++;
    chk("full_pop_no_consume", 64'(idx), 64'd4);
    cycle(1'b1, fl[idx], 1'b0, c);
    if (c) idx++;
    chk("fifth_accepted", 64'(idx), 64'd5);
    for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b1, c);

    // steady push+pop at level 2
    do_reset();
    cycle(1'b1, mk(8'd1, MY_ID, 32'hD0), 1'b0, c);
    cycle(1'b1, mk(8'd1, MY_ID, 32'hD1), 1'b0, c);
    for (int i = 0; i < 10; i++) cycle(1'b1, mk(8'd1, BROADCAST_ID, 32'hD2 + 32'(i)), 1'b1, c);
    chk("steady_level", {61'd0, lvl}, 64'd2);
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, c);

    // ROOT_ID: accepted only by the root instance
    do_reset();
    rf = mk(8'd3, ROOT_ID, 32'hE0);
    r_fin = rf; r_fvalid = 1'b1;
    cycle(1'b1, rf, 1'b1, c);
    r_fvalid = 1'b0;
    chk("root_acc", {48'd0, r_acc}, 64'd1);
    chk("root_drop", {48'd0, r_drp}, 64'd0);
    chk("root_valid", {63'd0, r_fovalid}, 64'd1);
    chk("root_flit", 64'(r_fout), 64'(rf));
    chk("nonroot_drop", {48'd0, drp}, 64'd1);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      s = ($urandom_range(0, 5) == 0) ? MY_ID : 8'($urandom_range(0, 255));
      case ($urandom_range(0, 4))
        0:       d = MY_ID;
        1:       d = BROADCAST_ID;
        2:       d = ROOT_ID;
        3:       d = 8'd7;
        default: d = 8'($urandom_range(0, 255));
      endcase
      cycle(1'($urandom_range(0, 1)), mk(s, d, $urandom), 1'($urandom_range(0, 2) != 0), c);
    end
    for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b1, c);

    // drop counter saturation, then reset with flits buffered
    do_reset();
    for (int i = 0; i < 65534; i++) cycle(1'b1, mk(8'd1, 8'd9, 32'(i)), 1'b1, c);
    chk("drop_preload", {48'd0, drp}, 64'hFFFE);
    for (int i = 0; i < 3; i++) cycle(1'b1, mk(8'd1, 8'd9, 32'hF0), 1'b1, c);
    chk("drop_saturated", {48'd0, drp}, 64'hFFFF);
    cycle(1'b1, mk(8'd1, MY_ID, 32'hF1), 1'b0, c);
    cycle(1'b1, mk(8'd1, MY_ID, 32'hF2), 1'b0, c);
    chk("two_buffered", {61'd0, lvl}, 64'd2);
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, c);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
